// File: rtl/acc_issue_sched_pkg.sv
// Shared constants and FSM encoding for the accelerator issue scheduler.
package acc_issue_sched_pkg;

  localparam int unsigned NREG       = 8;
  localparam int unsigned REG_W      = 3;
  localparam int unsigned NACC       = 2;
  localparam int unsigned ACC_SEL_W  = (NACC > 1) ? $clog2(NACC) : 1;
  localparam int unsigned STARVE_LIM = 4;
  localparam int unsigned STARVE_W   = $clog2(STARVE_LIM + 1);
  localparam int unsigned WDOG_W     = 16;

  // Accelerator slot indices
  localparam int unsigned ACC_FFT    = 0;
  localparam int unsigned ACC_CRYPTO = 1;

  // Per-accelerator FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

endpackage

// File: rtl/acc_issue_sched_if.sv
// ID-stage, accelerator handshake and write-port arbitration bundle.
interface acc_issue_sched_if;
  import acc_issue_sched_pkg::*;

  logic                 id_valid;
  logic [REG_W-1:0]     id_rs1;
  logic [REG_W-1:0]     id_rs2;
  logic [REG_W-1:0]     id_rd;
  logic                 id_is_acc;
  logic [ACC_SEL_W-1:0] id_acc_sel;
  logic                 hazard_stall;
  logic [NACC-1:0]      acc_done;
  logic                 pipe_wb_req;

  logic                 stall_id;
  logic                 flush_ex;
  logic [NACC-1:0]      acc_start;
  logic [NACC-1:0]      acc_wb_grant;
  logic [REG_W-1:0]     acc_wb_rd;
  logic                 pipe_wb_hold;
  logic [NREG-1:0]      sb_busy;
  logic                 timeout_err;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_is_acc, id_acc_sel,
           hazard_stall, acc_done, pipe_wb_req,
    input  stall_id, flush_ex, acc_start, acc_wb_grant, acc_wb_rd,
           pipe_wb_hold, sb_busy, timeout_err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_is_acc, id_acc_sel,
           hazard_stall, acc_done, pipe_wb_req,
    output stall_id, flush_ex, acc_start, acc_wb_grant, acc_wb_rd,
           pipe_wb_hold, sb_busy, timeout_err
  );

endinterface

// File: rtl/acc_issue_sched_slot_fsm.sv
// One accelerator slot: IDLE/RUN/WB sequencing, latched rd, starve counter.
// Optional RUN watchdog enabled by ACC_WATCHDOG_EN.
module acc_slot_fsm
  import acc_issue_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic             done_i,
  input  logic             grant_i,
  output logic [1:0]       state_o,
  output logic [REG_W-1:0] rd_o,
  output logic             starve_hit_c,
  output logic             timeout_c
);

  logic [1:0]          state_q, state_d;
  logic [REG_W-1:0]    rd_q, rd_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
`ifdef ACC_WATCHDOG_EN
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
`endif

  // Next-state, rd latch, starve counter and watchdog timeout
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    starve_d  = starve_q;
    timeout_c = 1'b0;
`ifdef ACC_WATCHDOG_EN
    wdog_d    = (state_q == ST_RUN) ? wdog_q + WDOG_W'(1) : '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (issue_i) begin
          state_d = ST_RUN;
          rd_d    = rd_i;
        end
      end
      ST_RUN: begin
        if (done_i) begin
          state_d = ST_WB;
        end
`ifdef ACC_WATCHDOG_EN
        else if (wdog_q == '1) begin
          state_d   = ST_IDLE;
          timeout_c = 1'b1;
        end
`endif
      end
      ST_WB: begin
        if (grant_i) begin
          state_d  = ST_IDLE;
          starve_d = '0;
        end else if (starve_q < STARVE_W'(STARVE_LIM)) begin
          starve_d = starve_q + STARVE_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Slot state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rd_q     <= '0;
      starve_q <= '0;
`ifdef ACC_WATCHDOG_EN
      wdog_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      starve_q <= starve_d;
`ifdef ACC_WATCHDOG_EN
      wdog_q   <= wdog_d;
`endif
    end
  end

  assign state_o      = state_q;
  assign rd_o         = rd_q;
  assign starve_hit_c = (state_q == ST_WB) && (starve_q >= STARVE_W'(STARVE_LIM));

endmodule

// File: rtl/acc_issue_sched.sv
// Accelerator issue scheduler: scoreboard stall, issue, write-port arbitration.
// Optional RUN watchdog enabled by ACC_WATCHDOG_EN (timeout_err tied 0 otherwise).
module acc_issue_sched
  import acc_issue_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  acc_issue_sched_if.slave  bus
);

  logic [1:0]           slot_state [NACC];
  logic [REG_W-1:0]     slot_rd    [NACC];
  logic [NACC-1:0]      starve_hit;
  logic [NACC-1:0]      timeout;
  logic [NACC-1:0]      issue_vec;
  logic [NACC-1:0]      grant_c;
  logic                 hold_c;
  logic [REG_W-1:0]     wb_rd_c;
  logic                 sb_hit_c, struct_hit_c, stall_c, issue_c;

  logic [NREG-1:0]      sb_busy_q, sb_busy_d;
  logic [NACC-1:0]      acc_start_q, acc_start_d;
  logic [ACC_SEL_W-1:0] ptr_q, ptr_d;

  // Stall merge and issue decode
  always_comb begin
    sb_hit_c     = bus.id_valid & (sb_busy_q[bus.id_rs1] | sb_busy_q[bus.id_rs2] |
                                   sb_busy_q[bus.id_rd]);
    struct_hit_c = bus.id_valid & bus.id_is_acc & (slot_state[bus.id_acc_sel] != ST_IDLE);
    stall_c      = bus.hazard_stall | sb_hit_c | struct_hit_c;
    issue_c      = bus.id_valid & bus.id_is_acc & ~stall_c;
    for (int i = 0; i < NACC; i++) begin
      issue_vec[i] = issue_c && (bus.id_acc_sel == ACC_SEL_W'(i));
    end
  end

  // Write-port arbitration: starvation override, then pipeline, then round-robin
  always_comb begin
    logic                 found;
    logic [ACC_SEL_W-1:0] idx;
    grant_c = '0;
    hold_c  = 1'b0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < NACC; i++) begin
      if (!found && starve_hit[i]) begin
        grant_c[i] = 1'b1;
        found      = 1'b1;
      end
    end
    if (found) begin
      hold_c = bus.pipe_wb_req;
    end else if (!bus.pipe_wb_req) begin
      for (int k = 0; k < NACC; k++) begin
        idx = ACC_SEL_W'((int'(ptr_q) + k) % NACC);
        if (!found && (slot_state[idx] == ST_WB)) begin
          grant_c[idx] = 1'b1;
          found        = 1'b1;
        end
      end
    end
  end

  // Scoreboard, pointer and start-pulse next state
  always_comb begin
    sb_busy_d   = sb_busy_q;
    ptr_d       = ptr_q;
    wb_rd_c     = '0;
    acc_start_d = issue_vec;
    for (int i = 0; i < NACC; i++) begin
      if (grant_c[i]) begin
        wb_rd_c = slot_rd[i];
        ptr_d   = ACC_SEL_W'((i + 1) % NACC);
      end
      if (grant_c[i] || timeout[i]) begin
        sb_busy_d[slot_rd[i]] = 1'b0;
      end
    end
    if (issue_c) begin
      sb_busy_d[bus.id_rd] = 1'b1;
    end
  end

  // Scheduler registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_busy_q   <= '0;
      acc_start_q <= '0;
      ptr_q       <= '0;
    end else begin
      sb_busy_q   <= sb_busy_d;
      acc_start_q <= acc_start_d;
      ptr_q       <= ptr_d;
    end
  end

  for (genvar g = 0; g < NACC; g++) begin : g_slot
    acc_slot_fsm u_slot (
      .clk          (clk),
      .rst          (rst),
      .issue_i      (issue_vec[g]),
      .rd_i         (bus.id_rd),
      .done_i       (bus.acc_done[g]),
      .grant_i      (grant_c[g]),
      .state_o      (slot_state[g]),
      .rd_o         (slot_rd[g]),
      .starve_hit_c (starve_hit[g]),
      .timeout_c    (timeout[g])
    );
  end

`ifdef ACC_WATCHDOG_EN
  logic timeout_err_q, timeout_err_d;

  // Sticky watchdog error
  always_comb begin
    timeout_err_d = timeout_err_q | (|timeout);
  end

  // Watchdog error register
  always_ff @(posedge clk) begin
    if (rst) timeout_err_q <= 1'b0;
    else     timeout_err_q <= timeout_err_d;
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.stall_id     = stall_c;
  assign bus.flush_ex     = stall_c;
  assign bus.acc_start    = acc_start_q;
  assign bus.acc_wb_grant = grant_c;
  assign bus.acc_wb_rd    = wb_rd_c;
  assign bus.pipe_wb_hold = hold_c;
  assign bus.sb_busy      = sb_busy_q;

endmodule

// File: tb/tb_acc_issue_sched.sv
// Directed self-checking bench for acc_issue_sched (watchdog leg under ACC_WATCHDOG_EN).
module tb_acc_issue_sched;
  import acc_issue_sched_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  acc_issue_sched_if bus ();

  acc_issue_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic is_acc, input logic sel,
                        input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd);
    bus.id_valid   = v;
    bus.id_is_acc  = is_acc;
    bus.id_acc_sel = sel;
    bus.id_rs1     = rs1;
    bus.id_rs2     = rs2;
    bus.id_rd      = rd;
  endtask

  initial begin
    rst              = 1'b1;
    set_id(0, 0, 0, 0, 0, 0);
    bus.hazard_stall = 1'b0;
    bus.acc_done     = '0;
    bus.pipe_wb_req  = 1'b0;
    nxt();
    nxt();
    rst = 1'b0;
    #1;
    chk("rst_sb_busy", 32'(bus.sb_busy), 32'h0);
    chk("rst_acc_start", 32'(bus.acc_start), 32'h0);
    chk("rst_grant", 32'(bus.acc_wb_grant), 32'h0);
    chk("rst_stall", 32'(bus.stall_id), 32'h0);
    chk("rst_hold", 32'(bus.pipe_wb_hold), 32'h0);
    chk("rst_timeout", 32'(bus.timeout_err), 32'h0);

    // hazard_stall alone stalls
    bus.hazard_stall = 1'b1;
    #1;
    chk("hazard_stall", 32'(bus.stall_id), 32'h1);
    chk("hazard_flush", 32'(bus.flush_ex), 32'h1);
    bus.hazard_stall = 1'b0;

    // Issue FFT rd=3
    set_id(1, 1, 0, 0, 0, 3);
    #1;
    chk("issue_fft_nostall", 32'(bus.stall_id), 32'h0);
    nxt();
    chk("fft_start", 32'(bus.acc_start), 32'h1);
    chk("fft_sb", 32'(bus.sb_busy), 32'h08);
    set_id(1, 0, 0, 3, 1, 2);
    #1;
    chk("dep_stall_c1", 32'(bus.stall_id), 32'h1);
    chk("dep_flush_c1", 32'(bus.flush_ex), 32'h1);
    nxt();
    chk("fft_start_pulse_end", 32'(bus.acc_start), 32'h0);
    chk("dep_stall_c2", 32'(bus.stall_id), 32'h1);
    bus.acc_done = 2'b01;
    nxt();
    bus.acc_done = 2'b00;
    #1;
    chk("fft_grant", 32'(bus.acc_wb_grant), 32'h1);
    chk("fft_wb_rd", 32'(bus.acc_wb_rd), 32'h3);
    chk("dep_stall_grant", 32'(bus.stall_id), 32'h1);
    nxt();
    chk("fft_sb_clear", 32'(bus.sb_busy), 32'h0);
    chk("dep_proceeds", 32'(bus.stall_id), 32'h0);
    chk("no_grant_after", 32'(bus.acc_wb_grant), 32'h0);

    // FFT rd=1, then structural hit, then crypto rd=5 issues alongside
    nxt();
    set_id(1, 1, 0, 0, 0, 1);
    #1;
    chk("fft2_issue", 32'(bus.stall_id), 32'h0);
    nxt();
    chk("fft2_sb", 32'(bus.sb_busy), 32'h02);
    chk("fft2_start", 32'(bus.acc_start), 32'h1);
    set_id(1, 1, 0, 0, 0, 4);
    #1;
    chk("struct_stall", 32'(bus.stall_id), 32'h1);
    chk("struct_flush", 32'(bus.flush_ex), 32'h1);
    nxt();
    chk("struct_no_start", 32'(bus.acc_start), 32'h0);
    set_id(1, 1, 1, 0, 0, 5);
    #1;
    chk("crypto_issue", 32'(bus.stall_id), 32'h0);
    nxt();
    chk("crypto_sb", 32'(bus.sb_busy), 32'h22);
    chk("crypto_start", 32'(bus.acc_start), 32'h2);

    // Crypto done while pipeline holds the port: starvation preemption
    set_id(0, 0, 0, 0, 0, 0);
    bus.acc_done    = 2'b10;
    bus.pipe_wb_req = 1'b1;
    #1;
    chk("crypto_run_nogrant", 32'(bus.acc_wb_grant), 32'h0);
    nxt();
    bus.acc_done = 2'b00;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("starve_c%0d_grant", c), 32'(bus.acc_wb_grant), 32'h0);
      chk($sformatf("starve_c%0d_hold", c), 32'(bus.pipe_wb_hold), 32'h0);
      nxt();
    end
    #1;
    chk("starve_grant", 32'(bus.acc_wb_grant), 32'h2);
    chk("starve_hold", 32'(bus.pipe_wb_hold), 32'h1);
    chk("starve_rd", 32'(bus.acc_wb_rd), 32'h5);
    nxt();
    chk("starve_sb", 32'(bus.sb_busy), 32'h02);
    chk("starve_hold_drop", 32'(bus.pipe_wb_hold), 32'h0);
    bus.pipe_wb_req = 1'b0;

    // Crypto rd=6, then both done together with pointer at 0
    set_id(1, 1, 1, 0, 0, 6);
    #1;
    chk("crypto2_issue", 32'(bus.stall_id), 32'h0);
    nxt();
    chk("crypto2_sb", 32'(bus.sb_busy), 32'h42);
    set_id(0, 0, 0, 0, 0, 0);
    bus.acc_done = 2'b11;
    nxt();
    bus.acc_done = 2'b00;
    #1;
    chk("both_grant0", 32'(bus.acc_wb_grant), 32'h1);
    chk("both_rd0", 32'(bus.acc_wb_rd), 32'h1);
    chk("both_sb0", 32'(bus.sb_busy), 32'h42);
    nxt();
    chk("both_grant1", 32'(bus.acc_wb_grant), 32'h2);
    chk("both_rd1", 32'(bus.acc_wb_rd), 32'h6);
    chk("both_sb1", 32'(bus.sb_busy), 32'h40);
    nxt();
    chk("both_done_grant", 32'(bus.acc_wb_grant), 32'h0);
    chk("both_done_sb", 32'(bus.sb_busy), 32'h0);

    // Reset while FFT runs, then a stray done
    set_id(1, 1, 0, 0, 0, 7);
    #1;
    chk("fft3_issue", 32'(bus.stall_id), 32'h0);
    nxt();
    chk("fft3_sb", 32'(bus.sb_busy), 32'h80);
    set_id(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    #1;
    chk("midrst_sb", 32'(bus.sb_busy), 32'h0);
    chk("midrst_start", 32'(bus.acc_start), 32'h0);
    chk("midrst_grant", 32'(bus.acc_wb_grant), 32'h0);
    chk("midrst_stall", 32'(bus.stall_id), 32'h0);
    bus.acc_done = 2'b01;
    nxt();
    bus.acc_done = 2'b00;
    #1;
    chk("stray_done_grant", 32'(bus.acc_wb_grant), 32'h0);
    chk("stray_done_sb", 32'(bus.sb_busy), 32'h0);
    set_id(1, 1, 0, 7, 0, 7);
    #1;
    chk("fft_idle_after_rst", 32'(bus.stall_id), 32'h0);
    nxt();
    chk("fft4_start", 32'(bus.acc_start), 32'h1);
    chk("fft4_sb", 32'(bus.sb_busy), 32'h80);
    chk("timeout_clear", 32'(bus.timeout_err), 32'h0);
    set_id(0, 0, 0, 0, 0, 0);

`ifdef ACC_WATCHDOG_EN
    begin
      int n;
      n = 0;
      while (!bus.timeout_err && n < 70000) begin
        nxt();
        n++;
      end
      chk("wdog_cycles", 32'(n), 32'd65536);
      chk("wdog_err", 32'(bus.timeout_err), 32'h1);
      chk("wdog_sb", 32'(bus.sb_busy), 32'h0);
      nxt();
      nxt();
      chk("wdog_sticky", 32'(bus.timeout_err), 32'h1);
      set_id(1, 1, 0, 0, 0, 2);
      #1;
      chk("wdog_fft_idle", 32'(bus.stall_id), 32'h0);
      set_id(0, 0, 0, 0, 0, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
